// File: rtl/icache_2way.sv
// rtl/icache_2way.sv - read-only 2-way set-associative L1 instruction cache
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   mem_read         : CPU fetch request, held until mem_resp
//   mem_address      : CPU fetch byte address ([1:0] ignored)
//   mem_rdata        : fetched instruction word (valid with mem_resp)
//   mem_resp         : fetch complete; combinational on a hit
//   pmem_read        : line-fill request, held until pmem_resp
//   pmem_address     : line-aligned fill address
//   pmem_rdata       : 256-bit fill line, byte 0 in [7:0]
//   pmem_resp        : fill data valid this cycle
module icache_2way #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic [31:0]  mem_address,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int SETS  = 2 ** S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]    valid0_q, valid1_q;
  logic [SETS-1:0]    lru_q;             // way to replace next
  logic [TAG_W-1:0]   tag_q  [2][SETS];
  logic [255:0]       data_q [2][SETS];

  logic [TAG_W-1:0]   fill_tag_q;
  logic [S_INDEX-1:0] fill_index_q;
  logic               fill_way_q;

  logic [2:0]         offset;
  logic [S_INDEX-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               hit0, hit1, hit, hit_way, victim;
  logic [255:0]       line;
  logic               hit_update, miss_start, fill_done;
  logic               unused_addr_bits;

  assign offset = mem_address[4:2];
  assign index  = mem_address[4+S_INDEX:5];
  assign tag    = mem_address[31:5+S_INDEX];
  assign unused_addr_bits = ^mem_address[1:0];

  assign hit0    = valid0_q[index] && (tag_q[0][index] == tag);
  assign hit1    = valid1_q[index] && (tag_q[1][index] == tag);
  assign hit     = hit0 || hit1;
  assign hit_way = hit1;
  assign line    = data_q[hit_way][index];

  // Fill an empty way before evicting anything; way 0 first.
  assign victim = !valid0_q[index] ? 1'b0 :
                  !valid1_q[index] ? 1'b1 : lru_q[index];

  // Fill address comes only from the latched miss, so a redirect of
  // mem_address while stalled cannot disturb the line in flight.
  assign pmem_address = {fill_tag_q, fill_index_q, 5'b0};

  always_comb begin
    state_d    = state_q;
    mem_resp   = 1'b0;
    mem_rdata  = 32'h0;
    pmem_read  = 1'b0;
    hit_update = 1'b0;
    miss_start = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read) begin
          if (hit) begin
            mem_resp   = 1'b1;
            mem_rdata  = line[{offset, 5'b0} +: 32];
            hit_update = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      valid0_q     <= '0;
      valid1_q     <= '0;
      lru_q        <= '0;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
      fill_way_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hit_update) begin
        lru_q[index] <= ~hit_way;
      end
      if (miss_start) begin
        fill_tag_q   <= tag;
        fill_index_q <= index;
        fill_way_q   <= victim;
      end
      if (fill_done) begin
        lru_q[fill_index_q] <= ~fill_way_q;
        if (fill_way_q) begin
          valid1_q[fill_index_q] <= 1'b1;
        end else begin
          valid0_q[fill_index_q] <= 1'b1;
        end
      end
    end
  end

  // Tag and data storage need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[fill_way_q][fill_index_q]  <= fill_tag_q;
      data_q[fill_way_q][fill_index_q] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_2way.sv
// tb/tb_icache_2way.sv - scoreboard testbench for icache_2way
module tb_icache_2way;

  logic         clk;
  logic         reset;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  icache_2way #(.S_INDEX(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mem_lat = 3;
  bit mem_enable = 1'b1;

  logic [31:0] resp_q[$];
  logic [31:0] fill_q[$];

  // Line word i = base + i, base = 0x1000_0000 | ((line_addr ^ 0x60) << 8)
  function automatic logic [255:0] make_line(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    base = 32'h1000_0000 | ((a ^ 32'h60) << 8);
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Memory responder: answers a fill after mem_lat cycles of pmem_read.
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp || reset || !pmem_read || !mem_enable) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          pmem_rdata = make_line(pmem_address);
          pmem_resp  = 1'b1;
        end
      end
    end
  end

  // Monitor: compares responses and fill starts against the queues.
  initial begin
    logic prev_pread;
    logic [31:0] e;
    prev_pread = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_resp) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got rdata %h want no response", mem_rdata);
        end else begin
          e = resp_q.pop_front();
          check("rdata", mem_rdata, e);
        end
      end
      if (pmem_read && !prev_pread) begin
        if (fill_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fill: got pmem_address %h want no fill", pmem_address);
        end else begin
          e = fill_q.pop_front();
          check("fill_addr", pmem_address, e);
        end
      end
      prev_pread = pmem_read;
    end
  end

  // One fetch: expected word and fill pushed, stall cycles checked here.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input bit miss, input int exp_stall);
    int stall;
    bit got;
    resp_q.push_back(d);
    if (miss) fill_q.push_back({a[31:5], 5'b0});
    @(posedge clk); #1;
    mem_read = 1'b1;
    mem_address = a;
    stall = 0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (mem_resp) got = 1'b1;
      else stall++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: addr %h got no resp want resp", a);
    end else begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("no_pread_at_resp", {31'b0, pmem_read}, 32'h0);
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  task automatic wait_neg(input string name, input bit pread_or_resp);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = pread_or_resp ? pmem_read : pmem_resp;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: got timeout want event", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset = 1'b1;
    mem_read = 1'b0;
    mem_address = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_mem_resp", {31'b0, mem_resp}, 32'h0);
    check("rst_pmem_read", {31'b0, pmem_read}, 32'h0);
    check("rst_pmem_address", pmem_address, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    reset = 1'b0;

    // Cold miss and same-line hit
    fetch(32'h0000_0064, 32'h1000_0001, 1'b1, 4);
    fetch(32'h0000_007C, 32'h1000_0007, 1'b0, 0);

    // Replacement in set 0
    fetch(32'h0000_0000, 32'h1000_6000, 1'b1, 4);
    fetch(32'h0000_0104, 32'h1001_6001, 1'b1, 4);
    fetch(32'h0000_001C, 32'h1000_6007, 1'b0, 0);
    fetch(32'h0000_0200, 32'h1002_6000, 1'b1, 4);
    fetch(32'h0000_0000, 32'h1000_6000, 1'b0, 0);
    fetch(32'h0000_0100, 32'h1001_6000, 1'b1, 4);

    // Idle: nothing happens, lru of set 0 keeps pointing at way 0
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_resp", {31'b0, mem_resp}, 32'h0);
      check("idle_pread", {31'b0, pmem_read}, 32'h0);
    end

    // Redirect mid-fill: 0x040 fill completes, then 0x300 is fetched
    fill_q.push_back(32'h0000_0040);
    fill_q.push_back(32'h0000_0300);
    resp_q.push_back(32'h1003_6000);
    @(posedge clk); #1;
    mem_read = 1'b1;
    mem_address = 32'h0000_0040;
    wait_neg("redirect_fill_start", 1'b1);
    @(posedge clk); #1;
    mem_address = 32'h0000_0300;
    wait_neg("redirect_pmem_resp", 1'b0);
    check("redirect_hold_addr", pmem_address, 32'h0000_0040);
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = mem_resp;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL redirect_resp: got timeout want resp");
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    fetch(32'h0000_0044, 32'h1000_2001, 1'b0, 0);
    // 0x300 replaced way 0 (0x000); 0x100 survives
    fetch(32'h0000_0100, 32'h1001_6000, 1'b0, 0);
    fetch(32'h0000_0000, 32'h1000_6000, 1'b1, 4);

    // mem_read dropped during a fill: line still installed, no response
    fill_q.push_back(32'h0000_00A0);
    @(posedge clk); #1;
    mem_read = 1'b1;
    mem_address = 32'h0000_00A0;
    wait_neg("drop_fill_start", 1'b1);
    @(posedge clk); #1;
    mem_read = 1'b0;
    wait_neg("drop_pmem_resp", 1'b0);
    repeat (3) @(negedge clk);
    fetch(32'h0000_00A8, 32'h1000_C002, 1'b0, 0);

    // Reset during a fill
    mem_enable = 1'b0;
    fill_q.push_back(32'h0000_00E0);
    @(posedge clk); #1;
    mem_read = 1'b1;
    mem_address = 32'h0000_00E0;
    wait_neg("rst_fill_start", 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_pread", {31'b0, pmem_read}, 32'h0);
    check("rst_async_addr", pmem_address, 32'h0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem_enable = 1'b1;
    fetch(32'h0000_00E0, 32'h1000_8000, 1'b1, 4);
    fetch(32'h0000_00A0, 32'h1000_C000, 1'b1, 4);

    repeat (3) @(negedge clk);
    check("resp_q_empty", 32'(resp_q.size()), 32'h0);
    check("fill_q_empty", 32'(fill_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_2way.md
Name: icache_2way

Overview:
- Read-only, 2-way set-associative L1 instruction cache on the CPU instruction port (cmem_*_a).
- Converts per-word instruction fetches into 256-bit line fills from the physical memory / L2 side.
- A hit is answered combinationally in the request cycle, so the pipeline stall term (read & !resp) stays low on hits.
- A miss runs a single outstanding line fill; the request completes once the line is installed.

Parameters:
- S_INDEX, 3, set-index bits; number of sets = 2**S_INDEX.
- Line size is fixed at 32 bytes (offset = addr[4:0]).
- TAG width = 27 - S_INDEX.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  CPU fetch request, level-held until mem_resp.
- mem_address  in  32  fetch byte address; bits [1:0] ignored.
- mem_rdata  out  32  fetched instruction word.
- mem_resp  out  1  fetch complete this cycle.
- pmem_read  out  1  line-fill request to memory, held until pmem_resp.
- pmem_address  out  32  line-aligned fill address (bits [4:0] = 0).
- pmem_rdata  in  256  fill line; byte 0 in bits [7:0].
- pmem_resp  in  1  fill data valid this cycle.

Behaviour:
- Address split: offset = addr[4:0], index = addr[4+S_INDEX:5], tag = addr[31:5+S_INDEX].
- State per set:
  - valid[2] bits.
  - tag[2] arrays.
  - data[2] 256-bit lines, flop-based with combinational read.
  - one lru bit (= the way to replace next).
- Reset (async, any state):
  - all valid bits and lru bits cleared; FSM to IDLE.
  - pmem_read = 0, mem_resp = 0, pmem_address = 0, mem_rdata = 0.
  - A fill in flight is abandoned; a late pmem_resp is ignored while in IDLE.
- Hit = valid[w] & tag[w] == addr tag, for either way. Both ways hitting cannot occur by construction.
- FSM states:
  - IDLE:
    - mem_read & hit: mem_resp = 1 and mem_rdata = data[hit_way][32*offset[4:2] +: 32], both combinational, same cycle. At the clock edge, lru[index] <= ~hit_way.
    - mem_read & !hit: at the clock edge, latch fill_tag, fill_index and victim way, then go to FILL. mem_resp stays 0.
    - Victim selection: first invalid way (way 0 preferred), else lru[index].
    - mem_read low: mem_resp = 0, no state change.
  - FILL:
    - pmem_read = 1 (registered state decode). pmem_address = {fill_tag, fill_index, 5'b0}, from the latched values.
    - mem_resp = 0 throughout.
    - On pmem_resp: write pmem_rdata to data[victim][fill_index], set tag, set valid, set lru[fill_index] <= ~victim, go to IDLE.
    - pmem_read deasserts the cycle after pmem_resp.
- Miss latency: request cycle + memory cycles until pmem_resp + 1. The IDLE re-lookup then hits.
- Address change mid-fill (branch redirect while stalled):
  - The fill always completes for the latched address; the new mem_address is never used for pmem_address during FILL.
  - After returning to IDLE, the new address is looked up normally: a hit responds, a miss starts a new fill.
- mem_read dropped during FILL: the fill still completes and installs the line; no mem_resp is generated.
- Only one outstanding fill; no write path. There are no CPU write inputs to this block; the CPU holds cmem_write_a = 0.
- mem_rdata is don't-care when mem_resp = 0. It is driven 0 in reset only.

Test Plan:
- Cold miss: reset, mem_read = 1, addr 0x0000_0064.
  - pmem_read = 1 with pmem_address = 0x0000_0060 the next cycle.
  - Drive pmem_resp after 3 cycles with line word i = 0x1000_0000 + i.
  - mem_resp follows one cycle after pmem_resp, with mem_rdata = 0x1000_0001. No pmem_read afterwards.
- Same-line hit: after the fill, addr 0x0000_007C.
  - mem_resp = 1 in the same cycle, mem_rdata = 0x1000_0007, pmem_read stays 0.
- Replacement (S_INDEX = 3): fill 0x000 (way0), fill 0x100 (way1), hit 0x000, then access 0x200.
  - The 0x200 access evicts the 0x100 line.
  - Afterwards 0x000 hits with 0 cycles of stall, and 0x100 misses with pmem_address = 0x100.
- Redirect mid-fill: miss on 0x040, then change mem_address to 0x300 before pmem_resp.
  - pmem_address stays 0x040 until pmem_resp.
  - The next cycle starts a fill with pmem_address = 0x300.
  - A later access to 0x040 hits.
- Reset mid-fill: assert reset during FILL.
  - pmem_read drops immediately (asynchronously).
  - A subsequent access to the same address misses again (valid cleared).
- Idle: mem_read = 0 for 10 cycles → mem_resp = 0, pmem_read = 0, lru unchanged.
